// File: rtl/int_ctrl.sv
// Vectored interrupt controller: N_SRC active-low sources with enable, two priority
// levels with one level of nesting, edge/level trigger and request/ack/RETI handshake.
module int_ctrl #(
  parameter int               N_SRC      = 5,
  parameter int               VEC_W      = 16,
  parameter logic [VEC_W-1:0] VEC_BASE   = 16'h0003,
  parameter int               VEC_STRIDE = 8,
  localparam int              IDX_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] int_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [N_SRC-1:0] cfg_wdata,
  input  logic             irq_ack,
  input  logic             reti,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  output logic [IDX_W-1:0] irq_idx,
  output logic [N_SRC-1:0] pend,
  output logic [1:0]       act
);

  logic [N_SRC-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [N_SRC-1:0] pend_e_q, pend_e_d;
  logic [N_SRC-1:0] ie_q, ie_d, ip_q, ip_d, it_q, it_d;
  logic             ea_q, ea_d;
  logic             in_high_q, in_high_d, in_low_q, in_low_d;
  logic             irq_req_q, irq_req_d;
  logic [IDX_W-1:0] irq_idx_q, irq_idx_d;
  logic [VEC_W-1:0] irq_vec_q, irq_vec_d;

  logic [N_SRC-1:0] fall, pend_v, elig_h, elig_l, ack_sel;
  logic             ack_ok, ack_high, found_h, found_l;
  logic [IDX_W-1:0] win_h, win_l, win_idx;

  always_comb begin
    s1_d = int_n;
    s2_d = s1_q;
    s3_d = s2_q;

    fall   = s3_q & ~s2_q;
    pend_v = (it_q & pend_e_q) | (~it_q & ~s2_q);

    // A high-priority service blocks everything; a low one blocks only low sources.
    elig_h = {N_SRC{ea_q & ~in_high_q}} & ie_q & pend_v & ip_q;
    elig_l = {N_SRC{ea_q & ~in_high_q & ~in_low_q}} & ie_q & pend_v & ~ip_q;

    found_h = 1'b0;
    found_l = 1'b0;
    win_h   = '0;
    win_l   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig_h[i]) begin
        found_h = 1'b1;
        win_h   = IDX_W'(i);
      end
      if (elig_l[i]) begin
        found_l = 1'b1;
        win_l   = IDX_W'(i);
      end
    end
    win_idx = found_h ? win_h : win_l;

    ack_ok  = irq_ack & irq_req_q;
    ack_sel = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ack_sel[i] = ack_ok && (irq_idx_q == IDX_W'(i));
    end
    ack_high = |(ack_sel & ip_q);

    // RETI retires the innermost level before a same-cycle ack opens a new one.
    in_high_d = in_high_q;
    in_low_d  = in_low_q;
    if (reti) begin
      if (in_high_q) in_high_d = 1'b0;
      else           in_low_d  = 1'b0;
    end
    if (ack_ok) begin
      if (ack_high) in_high_d = 1'b1;
      else          in_low_d  = 1'b1;
    end

    pend_e_d = (pend_e_q & ~ack_sel) | (fall & it_q);

    ie_d = ie_q;
    ip_d = ip_q;
    it_d = it_q;
    ea_d = ea_q;
    if (cfg_we) begin
      case (cfg_sel)
        2'd0: ie_d = cfg_wdata;
        2'd1: ip_d = cfg_wdata;
        2'd2: begin
          it_d     = cfg_wdata;
          pend_e_d = pend_e_d & ~(it_q & ~cfg_wdata);
        end
        default: ea_d = cfg_wdata[0];
      endcase
    end

    irq_req_d = (found_h | found_l) & ~ack_ok;
    irq_idx_d = irq_idx_q;
    irq_vec_d = irq_vec_q;
    if (irq_req_d) begin
      irq_idx_d = win_idx;
      irq_vec_d = VEC_BASE + VEC_W'(win_idx) * VEC_W'(VEC_STRIDE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= '1;
      s2_q      <= '1;
      s3_q      <= '1;
      pend_e_q  <= '0;
      ie_q      <= '0;
      ip_q      <= '0;
      it_q      <= '0;
      ea_q      <= 1'b0;
      in_high_q <= 1'b0;
      in_low_q  <= 1'b0;
      irq_req_q <= 1'b0;
      irq_idx_q <= '0;
      irq_vec_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      pend_e_q  <= pend_e_d;
      ie_q      <= ie_d;
      ip_q      <= ip_d;
      it_q      <= it_d;
      ea_q      <= ea_d;
      in_high_q <= in_high_d;
      in_low_q  <= in_low_d;
      irq_req_q <= irq_req_d;
      irq_idx_q <= irq_idx_d;
      irq_vec_q <= irq_vec_d;
    end
  end

  assign irq_req = irq_req_q;
  assign irq_idx = irq_idx_q;
  assign irq_vec = irq_vec_q;
  assign pend    = pend_v;
  assign act     = {in_high_q, in_low_q};

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: a stack-based service model checked every cycle, plus
// directed scenarios with hand-computed vectors and latencies.
module tb_int_ctrl;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] int_n = '1;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_sel = 2'd0;
  logic [N-1:0] cfg_wdata = '0;
  logic         irq_ack = 1'b0;
  logic         reti = 1'b0;
  logic         irq_req;
  logic [15:0]  irq_vec;
  logic [2:0]   irq_idx;
  logic [N-1:0] pend;
  logic [1:0]   act;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  int_ctrl #(.N_SRC(N), .VEC_W(16), .VEC_BASE(16'h0003), .VEC_STRIDE(8)) dut (
    .clk(clk), .reset(reset), .int_n(int_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .irq_ack(irq_ack), .reti(reti), .irq_req(irq_req),
    .irq_vec(irq_vec), .irq_idx(irq_idx), .pend(pend), .act(act)
  );

  always #5 clk = ~clk;

  // Model: int_n delay line, latched edge flags, config copy and a stack of
  // service levels (1 = high, 0 = low) pushed on ack and popped on RETI.
  logic [N-1:0] m_s1, m_s2, m_s3, m_pe, m_ie, m_ip, m_it;
  logic         m_ea, m_req;
  int           m_idx;
  logic [15:0]  m_vec;
  int           svc[$];

  function automatic logic [N-1:0] m_pend_f();
    return (m_it & m_pe) | (~m_it & ~m_s2);
  endfunction

  function automatic logic [1:0] m_act_f();
    logic [1:0] a;
    a = 2'b00;
    foreach (svc[j]) begin
      if (svc[j] == 1) a[1] = 1'b1;
      else             a[0] = 1'b1;
    end
    return a;
  endfunction

  task automatic model_step();
    logic [N-1:0] pv, fell;
    logic [1:0]   busy;
    bit           ack_ok;
    int           win;
    pv   = m_pend_f();
    fell = m_s3 & ~m_s2;
    busy = m_act_f();
    win  = -1;
    if (m_ea) begin
      for (int i = 0; i < N; i++)
        if (win < 0 && m_ie[i] && pv[i] && m_ip[i] && !busy[1]) win = i;
      for (int i = 0; i < N; i++)
        if (win < 0 && m_ie[i] && pv[i] && !m_ip[i] && busy == 2'b00) win = i;
    end
    ack_ok = irq_ack && m_req;
    if (reti && svc.size() > 0) void'(svc.pop_back());
    if (ack_ok) begin
      svc.push_back(m_ip[m_idx] ? 1 : 0);
      m_pe[m_idx] = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (m_it[i] && fell[i]) m_pe[i] = 1'b1;
    if (cfg_we) begin
      case (cfg_sel)
        2'd0: m_ie = cfg_wdata;
        2'd1: m_ip = cfg_wdata;
        2'd2: begin
          m_pe = m_pe & ~(m_it & ~cfg_wdata);
          m_it = cfg_wdata;
        end
        default: m_ea = cfg_wdata[0];
      endcase
    end
    if (ack_ok || win < 0) m_req = 1'b0;
    else begin
      m_req = 1'b1;
      m_idx = win;
      m_vec = 16'h0003 + 16'(8 * win);
    end
    m_s3 = m_s2;
    m_s2 = m_s1;
    m_s1 = int_n;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = '1; m_s2 = '1; m_s3 = '1;
      m_pe = '0; m_ie = '0; m_ip = '0; m_it = '0;
      m_ea = 1'b0; m_req = 1'b0; m_idx = 0; m_vec = '0;
      svc.delete();
    end else begin
      model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, a, e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en && reset) begin
      check("mdl_req",  32'(irq_req), 32'(m_req));
      check("mdl_idx",  32'(irq_idx), 32'(m_idx));
      check("mdl_vec",  32'(irq_vec), 32'(m_vec));
      check("mdl_pend", 32'(pend),    32'(m_pend_f()));
      check("mdl_act",  32'(act),     32'(m_act_f()));
    end
  end

  task automatic cfg(input logic [1:0] sel, input logic [N-1:0] d);
    @(negedge clk); cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = d;
    @(negedge clk); cfg_we = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    @(negedge clk); reti = 1'b1;
    @(negedge clk); reti = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input string name, input int idx, input logic [15:0] vec, input int limit);
    int k;
    k = 0;
    while (k < limit) begin
      @(posedge clk); #1;
      if (irq_req) break;
      k++;
    end
    if (!irq_req) begin
      checks++;
      failures++;
      $display("FAIL %s timeout irq_req actual=0 expected=1", name);
    end else begin
      check({name, "_idx"}, 32'(irq_idx), 32'(idx));
      check({name, "_vec"}, 32'(irq_vec), 32'(vec));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst_req",  32'(irq_req), 32'd0);
    check("rst_vec",  32'(irq_vec), 32'd0);
    check("rst_idx",  32'(irq_idx), 32'd0);
    check("rst_act",  32'(act),     32'd0);
    check("rst_pend", 32'(pend),    32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;

    // Edge source 1, low priority: four-edge latency, ack clears its flag.
    cfg(2'd3, 5'b00001);
    cfg(2'd0, 5'b00011);
    cfg(2'd2, 5'b00011);
    @(negedge clk); int_n[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("t1_early", 32'(irq_req), 32'd0);
    @(negedge clk); int_n[1] = 1'b1;
    @(posedge clk);
    #1;
    check("t1_req", 32'(irq_req), 32'd1);
    check("t1_vec", 32'(irq_vec), 32'h000B);
    check("t1_idx", 32'(irq_idx), 32'd1);
    pulse_ack();
    check("t1_ack_req",  32'(irq_req), 32'd0);
    check("t1_ack_act",  32'(act),     32'b01);
    check("t1_ack_pend", 32'(pend[1]), 32'd0);
    pulse_reti();
    check("t1_reti_act", 32'(act), 32'b00);
    pulse_ack();
    check("t1_stray_ack", 32'(act), 32'b00);

    // Sources 0 and 1 together; 1 is high priority.
    cfg(2'd1, 5'b00010);
    @(negedge clk); int_n[1:0] = 2'b00;
    idle(2); int_n[1:0] = 2'b11;
    wait_req("t2_first", 1, 16'h000B, 10);
    pulse_ack();
    check("t2_act_hi", 32'(act), 32'b10);
    idle(4);
    check("t2_hold", 32'(irq_req), 32'd0);
    pulse_reti();
    wait_req("t2_second", 0, 16'h0003, 3);
    pulse_ack();
    check("t2_act_lo", 32'(act), 32'b01);

    // High source 2 nests over low source 0; low source 4 waits for both RETIs.
    cfg(2'd0, 5'b10111);
    cfg(2'd1, 5'b00110);
    cfg(2'd2, 5'b10111);
    @(negedge clk); int_n[2] = 1'b0;
    idle(2); int_n[2] = 1'b1;
    wait_req("t3_high", 2, 16'h0013, 10);
    pulse_ack();
    check("t3_act_nest", 32'(act), 32'b11);
    @(negedge clk); int_n[4] = 1'b0;
    idle(2); int_n[4] = 1'b1;
    idle(6);
    check("t3_blocked2", 32'(irq_req), 32'd0);
    check("t3_pend4",    32'(pend[4]), 32'd1);
    pulse_reti();
    check("t3_act_one", 32'(act), 32'b01);
    idle(5);
    check("t3_blocked1", 32'(irq_req), 32'd0);
    pulse_reti();
    wait_req("t3_low", 4, 16'h0023, 3);
    pulse_ack();
    pulse_reti();
    check("t3_act_done", 32'(act), 32'b00);

    // Level source 3: held low re-requests one cycle after RETI; released does not.
    cfg(2'd0, 5'b11111);
    @(negedge clk); int_n[3] = 1'b0;
    wait_req("t4_level", 3, 16'h001B, 6);
    pulse_ack();
    check("t4_act",  32'(act),     32'b01);
    check("t4_pend", 32'(pend[3]), 32'd1);
    idle(3);
    check("t4_insvc", 32'(irq_req), 32'd0);
    @(negedge clk); reti = 1'b1;
    @(posedge clk);
    #1 check("t4_reti_edge", 32'(irq_req), 32'd0);
    @(negedge clk); reti = 1'b0;
    @(posedge clk);
    #1;
    check("t4_rereq",     32'(irq_req), 32'd1);
    check("t4_rereq_idx", 32'(irq_idx), 32'd3);
    pulse_ack();
    @(negedge clk); int_n[3] = 1'b1;
    idle(4);
    check("t4_released", 32'(pend[3]), 32'd0);
    pulse_reti();
    idle(5);
    check("t4_no_rereq", 32'(irq_req), 32'd0);
    check("t4_act_done", 32'(act),     32'b00);

    // New edge on source 0 in its ack cycle keeps it pending.
    @(negedge clk); int_n[0] = 1'b0;
    idle(2); int_n[0] = 1'b1;
    wait_req("t5_first", 0, 16'h0003, 10);
    idle(3);
    int_n[0] = 1'b0;
    idle(2);
    irq_ack = 1'b1;
    @(posedge clk);
    #1;
    check("t5_ack_req",   32'(irq_req), 32'd0);
    check("t5_ack_act",   32'(act),     32'b01);
    check("t5_pend_kept", 32'(pend[0]), 32'd1);
    @(negedge clk); irq_ack = 1'b0; int_n[0] = 1'b1;
    pulse_reti();
    wait_req("t5_second", 0, 16'h0003, 3);

    // Reset mid-service with a request up, then silence until reconfigured.
    pulse_ack();
    @(negedge clk); int_n[2] = 1'b0;
    idle(2); int_n[2] = 1'b1;
    wait_req("t6_high", 2, 16'h0013, 10);
    check("t6_pre_act", 32'(act), 32'b01);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_req",  32'(irq_req), 32'd0);
    check("t6_rst_vec",  32'(irq_vec), 32'd0);
    check("t6_rst_idx",  32'(irq_idx), 32'd0);
    check("t6_rst_act",  32'(act),     32'd0);
    check("t6_rst_pend", 32'(pend),    32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); int_n[1] = 1'b0;
    idle(2); int_n[1] = 1'b1;
    idle(8);
    check("t6_no_req", 32'(irq_req), 32'd0);
    cfg(2'd0, 5'b00010);
    cfg(2'd2, 5'b00010);
    cfg(2'd3, 5'b00001);
    @(negedge clk); int_n[1] = 1'b0;
    idle(2); int_n[1] = 1'b1;
    wait_req("t6_reconf", 1, 16'h000B, 10);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
